// File: rtl/hd_rst_seq.sv
// hd_rst_seq: synchronised, staggered multi-channel reset release plus RUN-phase clk_en divider; no backpressure.
// Define HD_RST_SEQ_CNT_EN to add the saturating sw_rst_cnt output.
module hd_rst_seq #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2,
  parameter int CNT_W          = 8,
  parameter int DIV_W          = 4
) (
  input  logic              clkin,
  input  logic              rstin,
  input  logic              sw_rst_req,
  input  logic [DIV_W-1:0]  div_ratio,
  output logic [NUM_CH-1:0] rstout,
  output logic              sw_rst_ack,
  output logic              clk_en,
  output logic              seq_done
`ifdef HD_RST_SEQ_CNT_EN
  ,
  output logic [7:0]        sw_rst_cnt
`endif
);

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [NUM_CH-1:0] REL_FIRST = (STAGGER_CYCLES == 0) ? {NUM_CH{1'b1}} : NUM_CH'(1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                sync_out;
  logic                sw_q;
  logic                sw_edge;
  logic                start_rel;
  logic [NUM_CH-1:0]   rel_next;
  logic [DIV_W-1:0]    div_lat;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_nxt;

  // Deassertion-only synchroniser: assertion is asynchronous through the flop reset.
  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign sw_edge  = sw_rst_req & ~sw_q;
  assign rel_next = (rstout << 1) | NUM_CH'(1);
  assign div_nxt  = (div_cnt == div_lat - DIV_W'(1)) ? '0 : div_cnt + DIV_W'(1);

  // The SYNC->HOLD edge already counts as the first hold cycle, so HOLD_CYCLES==1 releases from SYNC.
  always_comb begin
    start_rel = 1'b0;
    if (state == SYNC && sync_out && HOLD_CYCLES == 1)
      start_rel = 1'b1;
    else if (state == HOLD && cnt == HOLD_LAST)
      start_rel = 1'b1;
  end

  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      state      <= SYNC;
      cnt        <= '0;
      rstout     <= '0;
      sw_rst_ack <= 1'b0;
      clk_en     <= 1'b0;
      seq_done   <= 1'b0;
      div_lat    <= '0;
      div_cnt    <= '0;
      sw_q       <= 1'b0;
    end else begin
      sw_q       <= sw_rst_req;
      sw_rst_ack <= 1'b0;
      if (sw_edge && state != SYNC) begin
        state      <= HOLD;
        cnt        <= '0;
        rstout     <= '0;
        seq_done   <= 1'b0;
        clk_en     <= 1'b0;
        sw_rst_ack <= 1'b1;
      end else if (start_rel) begin
        rstout <= REL_FIRST;
        cnt    <= '0;
        if (&REL_FIRST) begin
          state    <= RUN;
          seq_done <= 1'b1;
          clk_en   <= 1'b1;
          div_lat  <= div_ratio;
          div_cnt  <= '0;
        end else begin
          state <= RELEASE;
        end
      end else begin
        case (state)
          SYNC: begin
            if (sync_out) begin
              state <= HOLD;
              cnt   <= CNT_W'(1);
            end
          end
          HOLD: begin
            cnt <= cnt + CNT_W'(1);
          end
          RELEASE: begin
            if (cnt == STAG_LAST) begin
              rstout <= rel_next;
              cnt    <= '0;
              if (&rel_next) begin
                state    <= RUN;
                seq_done <= 1'b1;
                clk_en   <= 1'b1;
                div_lat  <= div_ratio;
                div_cnt  <= '0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (div_lat <= DIV_W'(1)) begin
              clk_en <= 1'b1;
            end else begin
              div_cnt <= div_nxt;
              clk_en  <= (div_nxt == '0);
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

`ifdef HD_RST_SEQ_CNT_EN
  always_ff @(posedge clkin or negedge rstin) begin
    if (!rstin) begin
      sw_rst_cnt <= '0;
    end else if (sw_rst_ack && sw_rst_cnt != 8'hff) begin
      sw_rst_cnt <= sw_rst_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hd_rst_seq.sv
// Scoreboard bench for hd_rst_seq: expectations are queued per cycle and checked at the falling edge.
module tb_hd_rst_seq;

  logic       clkin;
  logic       rstin;
  logic       sw_rst_req;
  logic [3:0] div_ratio;
  logic [3:0] rstout;
  logic       sw_rst_ack;
  logic       clk_en;
  logic       seq_done;
  logic       sw0;
  logic [3:0] div0;
  logic [3:0] rstout0;
  logic       ack0;
  logic       clk_en0;
  logic       seq_done0;
`ifdef HD_RST_SEQ_CNT_EN
  logic [7:0] sw_rst_cnt;
`endif

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  hd_rst_seq dut (
    .clkin(clkin), .rstin(rstin), .sw_rst_req(sw_rst_req), .div_ratio(div_ratio),
    .rstout(rstout), .sw_rst_ack(sw_rst_ack), .clk_en(clk_en), .seq_done(seq_done)
`ifdef HD_RST_SEQ_CNT_EN
    , .sw_rst_cnt(sw_rst_cnt)
`endif
  );

  hd_rst_seq #(.HOLD_CYCLES(3), .STAGGER_CYCLES(0)) dut0 (
    .clkin(clkin), .rstin(rstin), .sw_rst_req(sw0), .div_ratio(div0),
    .rstout(rstout0), .sw_rst_ack(ack0), .clk_en(clk_en0), .seq_done(seq_done0)
`ifdef HD_RST_SEQ_CNT_EN
    , .sw_rst_cnt()
`endif
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(rstout);
      1: return 32'(seq_done);
      2: return 32'(sw_rst_ack);
      3: return 32'(clk_en);
      4: return 32'(rstout0);
      5: return 32'(seq_done0);
      6: return 32'(clk_en0);
      default: return 32'(ack0);
    endcase
  endfunction

  task automatic push(input int c, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clkin);
  endtask

  always @(negedge clkin) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk($sformatf("%s@%0d", sb[i].tag, sb[i].cyc), obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int e;
    rstin = 1'b0; sw_rst_req = 1'b0; div_ratio = 4'd3; sw0 = 1'b0; div0 = 4'd0;
    repeat (3) @(negedge clkin);
    chk("rst_rstout", 32'(rstout), 32'h0);
    chk("rst_seq_done", 32'(seq_done), 32'h0);
    chk("rst_ack", 32'(sw_rst_ack), 32'h0);
    chk("rst_clk_en", 32'(clk_en), 32'h0);

    // Board reset release; edge 1 is the next posedge.
    rstin = 1'b1; b = cyc;
    push(b+5, 0, 4'h0, "brd_rstout"); push(b+6, 0, 4'h1, "brd_rstout");
    push(b+7, 0, 4'h1, "brd_rstout"); push(b+8, 0, 4'h3, "brd_rstout");
    push(b+10, 0, 4'h7, "brd_rstout"); push(b+11, 1, 0, "brd_done");
    push(b+12, 0, 4'hf, "brd_rstout"); push(b+12, 1, 1, "brd_done");
    push(b+11, 3, 0, "div3"); push(b+12, 3, 1, "div3"); push(b+13, 3, 0, "div3");
    push(b+14, 3, 0, "div3"); push(b+15, 3, 1, "div3"); push(b+18, 3, 1, "div3");
    push(b+21, 3, 1, "div3"); push(b+22, 3, 0, "div3_chg"); push(b+23, 3, 0, "div3_chg");
    push(b+24, 3, 1, "div3_chg");
    push(b+4, 4, 4'h0, "stg0_rstout"); push(b+5, 4, 4'hf, "stg0_rstout");
    push(b+4, 5, 0, "stg0_done"); push(b+5, 5, 1, "stg0_done");
    push(b+6, 6, 1, "div0_clk_en"); push(b+7, 6, 1, "div0_clk_en"); push(b+6, 7, 0, "stg0_ack");
    wait_until(b+16);
    div_ratio = 4'd1;
    wait_until(b+26);

    // Single software request in RUN.
    e = cyc + 2;
    wait_until(e-1); sw_rst_req = 1'b1;
    push(e, 0, 4'h0, "sw_rstout"); push(e, 2, 1, "sw_ack"); push(e, 1, 0, "sw_done");
    push(e, 3, 0, "sw_clk_en"); push(e+1, 2, 0, "sw_ack"); push(e+3, 0, 4'h0, "sw_rstout");
    push(e+4, 0, 4'h1, "sw_rstout"); push(e+10, 0, 4'hf, "sw_rstout"); push(e+10, 1, 1, "sw_done");
    push(e+10, 3, 1, "div1"); push(e+11, 3, 1, "div1"); push(e+12, 3, 1, "div1");
    wait_until(e); sw_rst_req = 1'b0;
    wait_until(e+14);

    // Second request during HOLD restarts the hold count.
    e = cyc + 2;
    wait_until(e-1); sw_rst_req = 1'b1;
    push(e, 2, 1, "dbl_ack"); push(e+1, 2, 0, "dbl_ack"); push(e+2, 2, 1, "dbl_ack");
    push(e+3, 2, 0, "dbl_ack"); push(e+4, 0, 4'h0, "dbl_rstout"); push(e+5, 0, 4'h0, "dbl_rstout");
    push(e+6, 0, 4'h1, "dbl_rstout"); push(e+12, 0, 4'hf, "dbl_rstout");
    wait_until(e); sw_rst_req = 1'b0;
    wait_until(e+1); sw_rst_req = 1'b1;
    wait_until(e+2); sw_rst_req = 1'b0;
    wait_until(e+16);

    // Request held high: one ack only.
    e = cyc + 2;
    wait_until(e-1); sw_rst_req = 1'b1;
    push(e, 2, 1, "held_ack"); push(e+1, 2, 0, "held_ack"); push(e+5, 2, 0, "held_ack");
    push(e+9, 2, 0, "held_ack"); push(e+10, 0, 4'hf, "held_rstout");
    wait_until(e+12); sw_rst_req = 1'b0;
    wait_until(e+14);

    // Asynchronous abort in RELEASE, then restart with a request ignored in SYNC.
    e = cyc + 2;
    wait_until(e-1); sw_rst_req = 1'b1;
    push(e+4, 0, 4'h1, "abt_rstout"); push(e+6, 0, 4'h3, "abt_rstout");
    wait_until(e); sw_rst_req = 1'b0;
    wait_until(e+6);
    #2 rstin = 1'b0;
    #1;
    chk("abort_rstout", 32'(rstout), 32'h0);
    chk("abort_done", 32'(seq_done), 32'h0);
    chk("abort_clk_en", 32'(clk_en), 32'h0);
    chk("abort_rstout0", 32'(rstout0), 32'h0);
    @(negedge clkin);
    rstin = 1'b1; sw_rst_req = 1'b1; b = cyc;
    push(b+1, 2, 0, "sync_ack"); push(b+2, 2, 0, "sync_ack");
    push(b+5, 0, 4'h0, "re_rstout"); push(b+6, 0, 4'h1, "re_rstout");
    push(b+8, 0, 4'h3, "re_rstout"); push(b+12, 0, 4'hf, "re_rstout"); push(b+12, 1, 1, "re_done");
    wait_until(b+1); sw_rst_req = 1'b0;
    wait_until(b+14);

`ifdef HD_RST_SEQ_CNT_EN
    for (int k = 0; k < 260; k++) begin
      @(negedge clkin); sw_rst_req = 1'b1;
      @(negedge clkin); sw_rst_req = 1'b0;
    end
    repeat (2) @(negedge clkin);
    chk("cnt_sat", 32'(sw_rst_cnt), 32'd255);
    #2 rstin = 1'b0;
    #1 chk("cnt_clr", 32'(sw_rst_cnt), 32'd0);
    @(negedge clkin); rstin = 1'b1;
`endif

    repeat (3) @(negedge clkin);
    foreach (sb[i]) begin
      failures++;
      $display("FAIL unchecked %s@%0d", sb[i].tag, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
